mul_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8x8 shift-add multiplier between N_REQ requesters.
- Accepts one operand pair per handshake and sequences the multiplier's start/busy/done protocol.
- Returns the 16-bit product on a single shared response channel, tagged with the requester ID.
- Sits between the requesting datapaths and the multiplier, and guarantees the multiplier never receives a start while it is busy.

---
 rtl/mul_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one start/busy/done multiplier between N_REQ requesters.
// One operation outstanding at a time; response is tagged with the owning requester ID.
module mul_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2*W-1:0]       rsp_data,
  output logic                 rsp_err,
  output logic                 timeout_err,
  output logic                 mul_start,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic                 mul_busy,
  input  logic                 mul_done,
  input  logic [2*W-1:0]       mul_result
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [2*W-1:0]   rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic             mul_start_q, mul_start_d;

  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_idx;
  logic             grant_found;
  logic             grant_ok;
  int unsigned      cand;

  // First valid requester scanning from ptr upward, wrapping at N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand     = (32'(ptr_q) + k) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Accept is combinational and only offered while idle with the multiplier free.
  assign grant_ok  = (state_q == S_IDLE) && !mul_busy && grant_found && !reset;
  assign req_ready = grant_ok ? (N_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    rsp_valid_d   = rsp_valid_q;
    timeout_err_d = timeout_err_q;
    mul_start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          mul_a_d     = req_a[32'(grant_idx)*W +: W];
          mul_b_d     = req_b[32'(grant_idx)*W +: W];
          rsp_id_d    = grant_idx;
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done arriving in the timeout cycle still yields a good result.
        if (mul_done) begin
          rsp_data_d  = mul_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d    = '0;
          rsp_err_d     = 1'b1;
          timeout_err_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      mul_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      rsp_valid_q   <= rsp_valid_d;
      timeout_err_q <= timeout_err_d;
      mul_start_q   <= mul_start_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_err = timeout_err_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small start/busy/done multiplier responder.
module tb_mul_share_arbiter;

  localparam int unsigned TO = 32;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        timeout_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_busy;
  logic        mul_done;
  logic [15:0] mul_result;

  // responder model controls
  int          mdl_lat;
  logic        mdl_never;
  int          busy_cnt;
  logic        mdl_busy;
  logic [15:0] prod;

  int n_vec;
  int n_err;
  int cyc;
  logic any_rdy;
  int   n_start;

  mul_share_arbiter #(.N_REQ(4), .W(8), .ID_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .timeout_err(timeout_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_busy = mdl_busy;

  // Multiplier responder: done pulses mdl_lat cycles after the start edge.
  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (reset) begin
      busy_cnt <= 0;
      mdl_busy <= 1'b0;
    end else if (mul_start) begin
      busy_cnt <= mdl_lat;
      mdl_busy <= 1'b1;
      prod     <= 16'(mul_a) * 16'(mul_b);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        mdl_busy <= 1'b0;
        if (!mdl_never) begin
          mul_done   <= 1'b1;
          mul_result <= prod;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic wait_grant();
    int c;
    c = 0;
    while (req_ready == 4'd0 && c < 100) begin
      step();
      c++;
    end
  endtask

  // Returns cycles from the current sample point until rsp_valid is seen.
  task automatic wait_rsp(output int c);
    c = 0;
    while (!rsp_valid && c < 200) begin
      step();
      c++;
      if (req_ready != 4'd0) any_rdy = 1'b1;
      if (mul_start) n_start++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_id"},      32'(rsp_id),      32'd0);
    chk({tag, "_rsp_data"},    32'(rsp_data),    32'd0);
    chk({tag, "_rsp_err"},     32'(rsp_err),     32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_mul_start"},   32'(mul_start),   32'd0);
    chk({tag, "_mul_a"},       32'(mul_a),       32'd0);
    chk({tag, "_mul_b"},       32'(mul_b),       32'd0);
  endtask

  int   exp_id [5] = '{0, 1, 2, 3, 0};
  int   exp_d  [5] = '{6, 9, 12, 15, 6};
  logic stable;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    mdl_lat = 1; mdl_never = 1'b0;
    any_rdy = 1'b0; n_start = 0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst");

    // 1: single request from requester 1
    req_valid = 4'b0010; set_op(1, 8'd13, 8'd11);
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    #1;
    chk("t1_ready_drop", 32'(req_ready), 32'd0);
    chk("t1_start", 32'(mul_start), 32'd1);
    chk("t1_mul_a", 32'(mul_a), 32'd13);
    chk("t1_mul_b", 32'(mul_b), 32'd11);
    n_start = 0;
    wait_rsp(cyc);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_start_once", 32'(n_start), 32'd0);
    chk("t1_id", 32'(rsp_id), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'd143);
    chk("t1_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    chk("t1_valid_drop", 32'(rsp_valid), 32'd0);

    // 2: all four requesting continuously from a fresh pointer
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 2), 8'd3);
    req_valid = 4'b1111; rsp_ready = 1'b1; any_rdy = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      chk($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(4'd1 << exp_id[k]));
      step();
      wait_rsp(cyc);
      chk($sformatf("t2_id%0d", k), 32'(rsp_id), 32'(exp_id[k]));
      chk($sformatf("t2_data%0d", k), 32'(rsp_data), 32'(exp_d[k]));
      step();
    end
    chk("t2_no_extra_grant", 32'(any_rdy), 32'd0);
    req_valid = '0; rsp_ready = 1'b0;

    // 3: backpressure with requester 2 waiting (ptr now 1)
    set_op(0, 8'd7, 8'd9); set_op(2, 8'd20, 8'd10);
    req_valid = 4'b0001;
    #1;
    chk("t3_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100;
    wait_rsp(cyc);
    chk("t3_id", 32'(rsp_id), 32'd0);
    chk("t3_data", 32'(rsp_data), 32'd63);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(rsp_valid === 1'b1 && rsp_id === 2'd0 && rsp_data === 16'd63 &&
            req_ready === 4'd0 && mul_start === 1'b0)) stable = 1'b0;
    end
    chk("t3_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    #1;
    chk("t3_no_accept_in_handshake", 32'(req_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    #1;
    chk("t3_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    wait_rsp(cyc);
    chk("t3_id2", 32'(rsp_id), 32'd2);
    chk("t3_data2", 32'(rsp_data), 32'd200);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // 4: timeout, multiplier never signals done (ptr now 3)
    mdl_never = 1'b1; mdl_lat = 2;
    set_op(3, 8'd1, 8'd1); req_valid = 4'b1000;
    #1;
    chk("t4_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    chk("t4_start", 32'(mul_start), 32'd1);
    wait_rsp(cyc);
    chk("t4_latency", 32'(cyc), 32'(TO + 1));
    chk("t4_err", 32'(rsp_err), 32'd1);
    chk("t4_data", 32'(rsp_data), 32'd0);
    chk("t4_id", 32'(rsp_id), 32'd3);
    chk("t4_sticky", 32'(timeout_err), 32'd1);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    mdl_never = 1'b0; mdl_lat = 1;

    // 5: extremes (ptr now 0)
    set_op(0, 8'd255, 8'd255); req_valid = 4'b0001;
    #1;
    chk("t5_grant0", 32'(req_ready), 32'b0001);
    step(); req_valid = '0;
    wait_rsp(cyc);
    chk("t5_max", 32'(rsp_data), 32'd65025);
    chk("t5_max_err", 32'(rsp_err), 32'd0);
    chk("t5_sticky", 32'(timeout_err), 32'd1);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    set_op(1, 8'd0, 8'd77); req_valid = 4'b0010;
    #1;
    step(); req_valid = '0;
    wait_rsp(cyc);
    chk("t5_zero_id", 32'(rsp_id), 32'd1);
    chk("t5_zero", 32'(rsp_data), 32'd0);
    chk("t5_zero_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // done lands exactly in the timeout cycle
    mdl_lat = TO - 1;
    set_op(2, 8'd6, 8'd7); req_valid = 4'b0100;
    #1;
    chk("t5_grant2", 32'(req_ready), 32'b0100);
    step(); req_valid = '0;
    wait_rsp(cyc);
    chk("t5_coll_latency", 32'(cyc), 32'(TO + 1));
    chk("t5_coll_err", 32'(rsp_err), 32'd0);
    chk("t5_coll_data", 32'(rsp_data), 32'd42);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    mdl_lat = 1;

    // 6: reset during WAIT (ptr now 3)
    set_op(3, 8'd2, 8'd2); req_valid = 4'b1000;
    #1;
    chk("t6_grant3", 32'(req_ready), 32'b1000);
    step(); req_valid = '0;
    step();
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    chk_reset_outputs("wrst");
    repeat (4) step();
    chk("t6_no_rsp_after_wait_reset", 32'(rsp_valid), 32'd0);

    // reset during RESP
    req_valid = 4'b1000;
    #1;
    step(); req_valid = '0;
    wait_rsp(cyc);
    chk("t6_resp_data", 32'(rsp_data), 32'd4);
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    chk_reset_outputs("rrst");

    // pointer restarts at requester 0
    set_op(0, 8'd3, 8'd5); req_valid = 4'b1001;
    #1;
    chk("t6_ptr0_grant", 32'(req_ready), 32'b0001);
    step(); req_valid = '0;
    wait_rsp(cyc);
    chk("t6_final_id", 32'(rsp_id), 32'd0);
    chk("t6_final_data", 32'(rsp_data), 32'd15);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
